// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port, 1-cycle-latency synchronous memory
// between an instruction-fetch port (A, read-only) and a loader/debug port
// (B, read/write). Grants are combinational from valid + arbiter state, and
// each accepted request is answered exactly one cycle later on its own port.
`timescale 1ns/1ps

module imem_arbiter #(
  parameter int unsigned DP        = 1024,
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 16,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic [DW-1:0] mem_din,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // One extra bit so a depth equal to 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH    = (AW+1)'(DP);
  localparam logic [7:0]  WAIT_MAX = 8'(MAX_WAIT);

  logic       a_in_range;
  logic       b_in_range;
  logic       grant_a;
  logic       grant_b;
  logic [7:0] b_wait;
  port_e      last_grant_q;
  port_e      last_grant_d;

  // Response pipeline: one registered slot describing last cycle's acceptance.
  logic       rsp_valid;
  port_e      rsp_port;
  logic       rsp_rd;
  logic       rsp_err;
  logic       rsp_live;

  assign a_in_range = ({1'b0, a_addr} < DEPTH);
  assign b_in_range = ({1'b0, b_addr} < DEPTH);

  // Arbitration: pick at most one winner and compute the next conflict owner.
  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (PRIO_MODE == 0) begin
          grant_b = (b_wait == WAIT_MAX);
        end else begin
          grant_b = (last_grant_q == PORT_A);
        end
        grant_a      = !grant_b;
        last_grant_d = grant_b ? PORT_B : PORT_A;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Memory drive: only an in-range granted request reaches the memory.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_a && a_in_range) begin
      mem_addr = a_addr;
    end else if (grant_b && b_in_range) begin
      mem_addr = b_addr;
      mem_we   = b_we;
      mem_din  = b_we ? b_wdata : '0;
    end
  end

  // B starvation counter: counts stalled B cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst || !b_valid || grant_b) begin
      b_wait <= '0;
    end else if (b_wait != WAIT_MAX) begin
      b_wait <= b_wait + 8'd1;
    end
  end

  // Round-robin memory: remembers which port won the most recent conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Response slot: capture who was accepted, whether it reads, and range error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_port  <= PORT_A;
      rsp_rd    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= grant_a || grant_b;
      rsp_port  <= grant_b ? PORT_B : PORT_A;
      rsp_rd    <= grant_a || (grant_b && !b_we);
      if (grant_a) begin
        rsp_err <= !a_in_range;
      end else if (grant_b) begin
        rsp_err <= !b_in_range;
      end else begin
        rsp_err <= 1'b0;
      end
    end
  end

  // Response outputs: steered by the registered port id, forced low during rst
  // so a response pending from the pre-reset cycle never appears.
  always_comb begin
    rsp_live = rsp_valid && !rst;
    a_rvalid = rsp_live && (rsp_port == PORT_A);
    b_rvalid = rsp_live && (rsp_port == PORT_B);
    a_err    = a_rvalid && rsp_err;
    b_err    = b_rvalid && rsp_err;
    a_rdata  = (a_rvalid && rsp_rd && !rsp_err) ? mem_dout : '0;
    b_rdata  = (b_rvalid && rsp_rd && !rsp_err) ? mem_dout : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of imem_arbiter in fixed-priority (dut0)
// and round-robin (dut1) modes, each with its own behavioural memory.
`timescale 1ns/1ps

module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [15:0] a_addr;
  logic        b_valid;
  logic        b_we;
  logic [15:0] b_addr;
  logic [15:0] b_wdata;

  logic        a_ready0, a_rvalid0, a_err0, b_ready0, b_rvalid0, b_err0, mem_we0;
  logic [15:0] a_rdata0, b_rdata0, mem_din0, mem_addr0, mem_dout0;
  logic        a_ready1, a_rvalid1, a_err1, b_ready1, b_rvalid1, b_err1, mem_we1;
  logic [15:0] a_rdata1, b_rdata1, mem_din1, mem_addr1, mem_dout1;

  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];

  int errors = 0;
  int checks = 0;

  imem_arbiter #(.DP(1024), .DW(16), .AW(16), .PRIO_MODE(0), .MAX_WAIT(4)) dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready0), .a_addr(a_addr),
    .a_rvalid(a_rvalid0), .a_rdata(a_rdata0), .a_err(a_err0),
    .b_valid(b_valid), .b_ready(b_ready0), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0), .b_err(b_err0),
    .mem_din(mem_din0), .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_dout(mem_dout0)
  );

  imem_arbiter #(.DP(1024), .DW(16), .AW(16), .PRIO_MODE(1), .MAX_WAIT(4)) dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready1), .a_addr(a_addr),
    .a_rvalid(a_rvalid1), .a_rdata(a_rdata1), .a_err(a_err1),
    .b_valid(b_valid), .b_ready(b_ready1), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1), .b_err(b_err1),
    .mem_din(mem_din1), .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_dout(mem_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we0) mem0[mem_addr0[9:0]] <= mem_din0;
    mem_dout0 <= mem0[mem_addr0[9:0]];
    if (mem_we1) mem1[mem_addr1[9:0]] <= mem_din1;
    mem_dout1 <= mem1[mem_addr1[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int unsigned i = 0; i < 1024; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    mem0[0] = 16'hBEEF; mem1[0] = 16'hBEEF;
    mem0[1] = 16'h0111; mem1[1] = 16'h0111;
    mem0[2] = 16'h0222; mem1[2] = 16'h0222;
    mem0[5] = 16'h1234; mem1[5] = 16'h1234;

    rst = 1'b1; a_valid = 1'b0; a_addr = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    step(); step();

    // Reset: requests present but nothing granted or driven.
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 16'h0005; b_addr = 16'h0002;
    #1;
    check("rst_a_ready", 32'(a_ready0), 32'd0);
    check("rst_b_ready", 32'(b_ready0), 32'd0);
    check("rst_mem_we", 32'(mem_we0), 32'd0);
    check("rst_mem_addr", 32'(mem_addr0), 32'd0);
    check("rst_a_rvalid", 32'(a_rvalid0), 32'd0);
    check("rst_rr_a_ready", 32'(a_ready1), 32'd0);

    // Test 1: A reads 0x0005.
    step();
    rst = 1'b0; b_valid = 1'b0;
    #1;
    check("t1_a_ready", 32'(a_ready0), 32'd1);
    check("t1_mem_addr", 32'(mem_addr0), 32'h5);
    check("t1_mem_we", 32'(mem_we0), 32'd0);
    step();
    check("t1_a_rvalid", 32'(a_rvalid0), 32'd1);
    check("t1_a_rdata", 32'(a_rdata0), 32'h1234);
    check("t1_a_err", 32'(a_err0), 32'd0);
    check("t1_b_rvalid", 32'(b_rvalid0), 32'd0);
    a_valid = 1'b0;
    step();
    check("t1_idle_a_rvalid", 32'(a_rvalid0), 32'd0);

    // Test 2: B writes 0x00AA to 0x0010, then reads it back.
    b_valid = 1'b1; b_we = 1'b1; b_addr = 16'h0010; b_wdata = 16'h00AA;
    #1;
    check("t2_b_ready_wr", 32'(b_ready0), 32'd1);
    check("t2_mem_we", 32'(mem_we0), 32'd1);
    check("t2_mem_addr", 32'(mem_addr0), 32'h10);
    check("t2_mem_din", 32'(mem_din0), 32'hAA);
    step();
    check("t2_b_rvalid_wr", 32'(b_rvalid0), 32'd1);
    check("t2_b_rdata_wr", 32'(b_rdata0), 32'd0);
    check("t2_b_err_wr", 32'(b_err0), 32'd0);
    b_we = 1'b0;
    #1;
    check("t2_b_ready_rd", 32'(b_ready0), 32'd1);
    check("t2_mem_we_rd", 32'(mem_we0), 32'd0);
    step();
    check("t2_b_rvalid_rd", 32'(b_rvalid0), 32'd1);
    check("t2_b_rdata_rd", 32'(b_rdata0), 32'h00AA);
    b_valid = 1'b0;
    step();

    // Test 3: fixed priority with anti-starvation: A,A,A,A,B,A.
    a_valid = 1'b1; a_addr = 16'h0001;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t3_a_ready_%0d", i), 32'(a_ready0), (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("t3_b_ready_%0d", i), 32'(b_ready0), (i == 4) ? 32'd1 : 32'd0);
      step();
      if (i == 4) begin
        check("t3_b_rvalid", 32'(b_rvalid0), 32'd1);
        check("t3_b_rdata", 32'(b_rdata0), 32'h0222);
        check("t3_a_rvalid_off", 32'(a_rvalid0), 32'd0);
      end else begin
        check($sformatf("t3_a_rvalid_%0d", i), 32'(a_rvalid0), 32'd1);
        check($sformatf("t3_a_rdata_%0d", i), 32'(a_rdata0), 32'h0111);
        check($sformatf("t3_b_rvalid_%0d", i), 32'(b_rvalid0), 32'd0);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Test 4: round-robin after reset: A,B,A,B.
    rst = 1'b1;
    step();
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_a_ready_%0d", i), 32'(a_ready1), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t4_b_ready_%0d", i), 32'(b_ready1), (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Test 5: out-of-range B write, then out-of-range A read.
    b_valid = 1'b1; b_we = 1'b1; b_addr = 16'h0400; b_wdata = 16'h5555;
    #1;
    check("t5_b_ready", 32'(b_ready0), 32'd1);
    check("t5_mem_we", 32'(mem_we0), 32'd0);
    check("t5_mem_addr", 32'(mem_addr0), 32'd0);
    step();
    check("t5_b_rvalid", 32'(b_rvalid0), 32'd1);
    check("t5_b_err", 32'(b_err0), 32'd1);
    check("t5_b_rdata", 32'(b_rdata0), 32'd0);
    b_valid = 1'b0; b_we = 1'b0;
    a_valid = 1'b1; a_addr = 16'hFFFF;
    #1;
    check("t5_a_ready_oor", 32'(a_ready0), 32'd1);
    check("t5_mem_addr_oor", 32'(mem_addr0), 32'd0);
    step();
    check("t5_a_rvalid_oor", 32'(a_rvalid0), 32'd1);
    check("t5_a_err_oor", 32'(a_err0), 32'd1);
    check("t5_a_rdata_oor", 32'(a_rdata0), 32'd0);

    // Test 6: reset right after an A acceptance discards the response.
    a_addr = 16'h0005;
    #1;
    check("t6_a_ready", 32'(a_ready0), 32'd1);
    step();
    rst = 1'b1; a_valid = 1'b0;
    #1;
    check("t6_a_rvalid_rst", 32'(a_rvalid0), 32'd0);
    check("t6_a_rdata_rst", 32'(a_rdata0), 32'd0);
    check("t6_a_err_rst", 32'(a_err0), 32'd0);
    check("t6_b_rvalid_rst", 32'(b_rvalid0), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("t6_a_rvalid_after", 32'(a_rvalid0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
